// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP capture path: FSM state encoding,
// decimation codes and small constant helpers.
package dvp_pkg;

  localparam logic [1:0] ST_WAIT_VS = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  localparam logic [1:0] DECIM_1 = 2'd0;
  localparam logic [1:0] DECIM_2 = 2'd1;
  localparam logic [1:0] DECIM_4 = 2'd2;

  // Never returns less than 1 so counters always have at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Low-order offset bits that must be zero for a pixel to survive decimation.
  function automatic logic [1:0] decim_mask(input logic [1:0] decim);
    logic [1:0] mask;
    case (decim)
      DECIM_1: mask = 2'b00;
      DECIM_2: mask = 2'b01;
      DECIM_4: mask = 2'b11;
      default: mask = 2'b11;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dvp_win_filter.sv
// Crop-window and decimation accept check for one pixel position against
// the frame's shadow configuration.
module dvp_win_filter
  import dvp_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_w,
  input  logic [Y_W-1:0] i_h,
  input  logic [1:0]     i_decim,
  output logic           o_hit
);

  logic [X_W:0] w_dx;
  logic [Y_W:0] w_dy;
  logic [1:0]   w_mask;
  logic         w_x_in;
  logic         w_y_in;

  // The extra top bit of each offset is the borrow, i.e. position < origin.
  always_comb begin
    w_dx   = {1'b0, i_x} - {1'b0, i_x0};
    w_dy   = {1'b0, i_y} - {1'b0, i_y0};
    w_mask = decim_mask(i_decim);
    w_x_in = ~w_dx[X_W] && (w_dx[X_W-1:0] < i_w) && ((w_dx[1:0] & w_mask) == 2'b00);
    w_y_in = ~w_dy[Y_W] && (w_dy[Y_W-1:0] < i_h) && ((w_dy[1:0] & w_mask) == 2'b00);
    o_hit  = w_x_in && w_y_in;
  end

endmodule

// File: rtl/dvp_capture_win.sv
// DVP byte-pair capture with runtime crop window and decimation, producing
// linear frame-buffer writes plus frame and error status.
module dvp_capture_win
  import dvp_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 17,
  parameter int FCNT_W = 8,
  localparam int X_W   = clog2(IMG_W),
  localparam int Y_W   = clog2(IMG_H)
) (
  input  logic              pclk,
  input  logic              iRST_N,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              capture_en,
  input  logic [X_W-1:0]    win_x0,
  input  logic [Y_W-1:0]    win_y0,
  input  logic [X_W-1:0]    win_w,
  input  logic [Y_W-1:0]    win_h,
  input  logic [1:0]        decim,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              ovf,
  output logic              line_err
);

  localparam logic [X_W-1:0]    X_MAX    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  logic              r_vs, r_vs_d, r_hr, r_hr_d;
  logic [7:0]        r_d, r_hi;
  logic [1:0]        r_state;
  logic              r_en;
  logic [X_W-1:0]    r_x0, r_w, r_x;
  logic [Y_W-1:0]    r_y0, r_h, r_y;
  logic [1:0]        r_dec;
  logic              r_x_sat, r_phase, r_line_px;
  logic [ADDR_W-1:0] r_next, r_addr;
  logic              r_full;
  logic              r_we, r_frame_done, r_ovf, r_line_err;
  logic [15:0]       r_dout;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_vs_rise, w_vs_fall, w_hr_fall;
  logic w_active, w_pix, w_hit, w_accept, w_latch;

  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  assign w_hr_fall = ~r_hr & r_hr_d;
  assign w_active  = (r_state == ST_ACTIVE);
  assign w_pix     = w_active & r_hr & r_phase;
  assign w_accept  = w_pix & ~r_x_sat & w_hit;
  assign w_latch   = w_vs_rise & ((r_state == ST_WAIT_VS) | (r_state == ST_ACTIVE));

  assign we         = r_we;
  assign addr       = r_addr;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign ovf        = r_ovf;
  assign line_err   = r_line_err;

  dvp_win_filter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_filter (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_w     (r_w),
    .i_h     (r_h),
    .i_decim (r_dec),
    .o_hit   (w_hit)
  );

  // Input sampling: sync signals and data share one register stage so they stay aligned.
  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hr   <= 1'b0;
      r_hr_d <= 1'b0;
      r_d    <= 8'd0;
    end else begin
      r_vs   <= vsync;
      r_vs_d <= r_vs;
      r_hr   <= href;
      r_hr_d <= r_hr;
      r_d    <= d;
    end
  end

  // Frame FSM, byte pairing, line accounting and write generation.
  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= ST_WAIT_VS;
      r_en         <= 1'b0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_dec        <= 2'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_x_sat      <= 1'b0;
      r_phase      <= 1'b0;
      r_line_px    <= 1'b0;
      r_hi         <= 8'd0;
      r_next       <= '0;
      r_full       <= 1'b0;
      r_addr       <= '0;
      r_dout       <= 16'd0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_ovf        <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_active && r_hr) begin
        if (!r_phase) begin
          r_hi    <= r_d;
          r_phase <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_line_px <= 1'b1;
          if (r_x == X_MAX) begin
            r_x_sat <= 1'b1;
          end else begin
            r_x <= r_x + X_W'(1);
          end
        end
      end else if (w_active && w_hr_fall) begin
        if (r_phase) begin
          r_line_err <= 1'b1;
        end
        r_phase   <= 1'b0;
        r_x       <= '0;
        r_x_sat   <= 1'b0;
        r_line_px <= 1'b0;
        if (r_line_px && (r_y != Y_MAX)) begin
          r_y <= r_y + Y_W'(1);
        end
      end

      // Once MAX_ADDR has been written the frame is full; later hits only flag ovf.
      if (w_accept) begin
        if (r_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_we   <= 1'b1;
          r_addr <= r_next;
          r_dout <= {r_hi, r_d};
          if (r_next == MAX_ADDR) begin
            r_full <= 1'b1;
          end else begin
            r_next <= r_next + ADDR_W'(1);
          end
        end
      end

      case (r_state)
        ST_WAIT_VS: begin
          if (w_vs_rise) begin
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_vs_fall) begin
            r_state <= r_en ? ST_ACTIVE : ST_WAIT_VS;
          end
        end
        ST_ACTIVE: begin
          if (w_vs_rise) begin
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
            r_state      <= capture_en ? ST_ACTIVE : ST_ARMED;
          end
        end
        default: r_state <= ST_WAIT_VS;
      endcase

      // Frame start overrides any line-end update made on the same edge.
      if (w_latch) begin
        r_en      <= capture_en;
        r_x0      <= win_x0;
        r_y0      <= win_y0;
        r_w       <= win_w;
        r_h       <= win_h;
        r_dec     <= decim;
        r_x       <= '0;
        r_y       <= '0;
        r_x_sat   <= 1'b0;
        r_phase   <= 1'b0;
        r_line_px <= 1'b0;
        r_next    <= '0;
        r_full    <= 1'b0;
        r_addr    <= '0;
      end
    end
  end

endmodule
